ram_sync_clr: RTL and testbench



---
 rtl/ram_sync_clr.sv | 75 +++++++
 tb/tb_ram_sync_clr.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ram_sync_clr.sv
// ram_sync_clr: synchronous RAM with registered read, selectable read-during-write and a built-in clear engine
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset; restarts the clear engine
//   CS         chip select; 0 means no access and dataOut holds
//   write_en   1 = write, 0 = read (qualified by CS)
//   addr       word address; addresses >= DEPTH read as 0 and ignore writes
//   dataIN     write data
//   clear_req  single-cycle pulse, starts a full clear from IDLE
//   dataOut    registered read data (one-cycle latency)
//   ready      1 while accesses are accepted (IDLE)
module ram_sync_clr #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  parameter int DEPTH = 16,
  parameter int RDW_MODE = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CS,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] dataIN,
  input  logic              clear_req,
  output logic [DATA_W-1:0] dataOut,
  output logic              ready
);
  localparam int PTR_W = ADDR_W > 1 ? ADDR_W : 1;
  typedef enum logic {CLEAR, IDLE} stateT;
  stateT state, nextState;
  logic [PTR_W-1:0] ptr, nextPtr, wrAddr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] nextOut, wrData, rdData;
  logic wrEn, inRange, lastPtr;
  assign inRange = 32'(addr) < DEPTH;
  // terminal compare against DEPTH-1 so ptr never needs to hold DEPTH
  assign lastPtr = ptr == PTR_W'(DEPTH - 1);
  assign rdData = inRange ? mem[addr] : '0;
  assign ready = state == IDLE;
  always_comb begin
    nextState = state;
    nextPtr = ptr;
    wrEn = 1'b0;
    wrAddr = PTR_W'(addr);
    wrData = dataIN;
    nextOut = dataOut;
    if (state == CLEAR) begin
      wrEn = 1'b1;
      wrAddr = ptr;
      wrData = CLEAR_VAL;
      nextPtr = lastPtr ? '0 : ptr + 1'b1;
      nextState = lastPtr ? IDLE : CLEAR;
    end else if (clear_req) begin
      nextPtr = '0;
      nextState = CLEAR;
    end else if (CS) begin
      wrEn = write_en && inRange;
      nextOut = (write_en && RDW_MODE == 1 && inRange) ? dataIN : rdData;
    end
  end
  // array has no reset so it can map onto block RAM; the clear engine zeroes it
  always_ff @(posedge clk)
    if (wrEn) mem[wrAddr] <= wrData;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= CLEAR;
      ptr <= '0;
      dataOut <= '0;
    end else begin
      state <= nextState;
      ptr <= nextPtr;
      dataOut <= nextOut;
    end
endmodule

// File: tb/tb_ram_sync_clr.sv
// tb_ram_sync_clr: randomized and directed check of ram_sync_clr against an array/countdown reference model
module tb_ram_sync_clr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cs = 1'b0, we = 1'b0, clearReq = 1'b0;
  logic [3:0] addr = '0, din = '0;
  logic [3:0] dOut [3];
  logic rdy [3];
  int total = 0, bad = 0;
  int mm [3][16];
  int mo [3];
  int left [3];

  always #5 clk = ~clk;

  ram_sync_clr #(.RDW_MODE(0)) dutA (.clk(clk), .rst(rst), .CS(cs), .write_en(we), .addr(addr),
    .dataIN(din), .clear_req(clearReq), .dataOut(dOut[0]), .ready(rdy[0]));
  ram_sync_clr #(.RDW_MODE(1)) dutB (.clk(clk), .rst(rst), .CS(cs), .write_en(we), .addr(addr),
    .dataIN(din), .clear_req(clearReq), .dataOut(dOut[1]), .ready(rdy[1]));
  ram_sync_clr #(.DEPTH(10)) dutC (.clk(clk), .rst(rst), .CS(cs), .write_en(we), .addr(addr),
    .dataIN(din), .clear_req(clearReq), .dataOut(dOut[2]), .ready(rdy[2]));

  function automatic int dep(input int k);
    return k == 2 ? 10 : 16;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic startClear(input int k);
    left[k] = dep(k);
    for (int j = 0; j < 16; j++) mm[k][j] = 0;
  endtask

  task automatic checkAll();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("ready%0d", k), 32'(rdy[k]), 32'(left[k] == 0));
      check($sformatf("dout%0d", k), 32'(dOut[k]), 32'(mo[k]));
    end
  endtask

  task automatic tick();
    for (int k = 0; k < 3; k++)
      if (rst) begin
        startClear(k);
        mo[k] = 0;
      end else if (left[k] > 0) left[k]--;
      else if (clearReq) startClear(k);
      else if (cs) begin
        if (int'(addr) >= dep(k)) mo[k] = 0;
        else begin
          mo[k] = (we && k == 1) ? int'(din) : mm[k][addr];
          if (we) mm[k][addr] = int'(din);
        end
      end
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic acc(input logic c, input logic w, input int a, input int d);
    cs = c;
    we = w;
    addr = 4'(a);
    din = 4'(d);
    tick();
  endtask

  task automatic asyncReset();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      startClear(k);
      mo[k] = 0;
    end
    checkAll();
    tick();
    rst = 1'b0;
  endtask

  task automatic waitReady(input int k, input int expN);
    int n = 0;
    cs = 1'b0;
    clearReq = 1'b0;
    while (!rdy[k] && n < 50) begin
      tick();
      n++;
    end
    check($sformatf("clrlen%0d", k), n, expN);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      startClear(k);
      mo[k] = 0;
    end
    tick();
    tick();
    check("rst_ready", 32'(rdy[0]), 0);
    rst = 1'b0;
    waitReady(0, 16);
    for (int i = 0; i < 16; i++) acc(1, 0, i, 0);
    acc(1, 1, 1, 9);
    acc(1, 0, 1, 0);
    check("rd1", 32'(dOut[0]), 9);
    acc(1, 0, 2, 0);
    check("rd2", 32'(dOut[0]), 0);
    acc(1, 1, 3, 5);
    acc(1, 1, 3, 10);
    check("rdw_old", 32'(dOut[0]), 5);
    check("rdw_new", 32'(dOut[1]), 10);
    acc(1, 0, 1, 0);
    acc(0, 1, 4, 7);
    check("cs0_hold", 32'(dOut[0]), 9);
    acc(0, 0, 4, 0);
    acc(1, 0, 4, 0);
    check("cs0_nowr", 32'(dOut[0]), 0);
    acc(1, 1, 12, 6);
    acc(1, 0, 12, 0);
    check("oor_c", 32'(dOut[2]), 0);
    check("oor_a", 32'(dOut[0]), 6);
    for (int i = 0; i < 16; i++) acc(1, 1, i, 15 - i);
    acc(1, 0, 0, 0);
    check("fill0", 32'(dOut[0]), 15);
    cs = 1'b1; we = 1'b1; addr = 4'd0; din = 4'd3; clearReq = 1'b1;
    tick();
    clearReq = 1'b0;
    check("clr_ready", 32'(rdy[0]), 0);
    for (int i = 0; i < 4; i++) acc(1, 1, i, 7);
    clearReq = 1'b1;
    tick();
    waitReady(0, 11);
    for (int i = 0; i < 16; i++) begin
      acc(1, 0, i, 0);
      check("clr_rd", 32'(dOut[0]), 0);
    end
    clearReq = 1'b1;
    tick();
    clearReq = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    asyncReset();
    waitReady(2, 10);
    waitReady(0, 6);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 249) == 0) asyncReset();
      clearReq = $urandom_range(0, 59) == 0;
      acc($urandom_range(0, 3) != 0, 1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end
    clearReq = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
